// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART_TX between NUM_REQ byte sources (optional watchdog via `UART_ARB_WDOG_EN)
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WDOG_CYC = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_par_en,
  input  logic [NUM_REQ-1:0]         req_par_typ,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       busy,
  output logic [7:0]                 P_DATA,
  output logic                       Data_Valid,
  output logic                       PAR_EN,
  output logic                       PAR_TYP,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       wdog_err
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [GW-1:0] rr_ptr, g, nxt;
  logic [2*NUM_REQ-1:0] dbl;
  logic found;
  int s;
`ifdef UART_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wcnt;
`endif
  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYC < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYC >= 1");
  end
  // Rotating the request vector by rr_ptr turns round-robin into a plain lowest-index priority search
  assign dbl = {req_valid, req_valid} >> rr_ptr;
  assign nxt = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign arb_busy = state != IDLE;
  assign req_ready = (!RST && state == IDLE && found) ? NUM_REQ'(1) << g : '0;
  // Pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    g = '0;
    s = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      s = s >= NUM_REQ ? s - NUM_REQ : s;
      if (dbl[k]) begin
        found = 1'b1;
        g = GW'(s);
      end
    end
  end
  // Frame sequencer: accept, pulse Data_Valid, then follow UART_TX busy to frame end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rr_ptr <= '0;
      P_DATA <= '0;
      Data_Valid <= 1'b0;
      PAR_EN <= 1'b0;
      PAR_TYP <= 1'b0;
      grant_id <= '0;
      wdog_err <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      wcnt <= '0;
`endif
    end else begin
      Data_Valid <= 1'b0;
      wdog_err <= 1'b0;
      case (state)
        IDLE: if (found) begin
          P_DATA <= req_data[{g, 3'b000} +: 8];
          PAR_EN <= req_par_en[g];
          PAR_TYP <= req_par_typ[g];
          grant_id <= g;
          Data_Valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT_BUSY;
`ifdef UART_ARB_WDOG_EN
          wcnt <= '0;
`endif
        end
        WAIT_BUSY: if (busy) state <= WAIT_DONE;
`ifdef UART_ARB_WDOG_EN
        else if (wcnt == CW'(WDOG_CYC - 1)) begin
          wdog_err <= 1'b1;
          rr_ptr <= nxt;
          state <= IDLE;
        end else wcnt <= wcnt + 1'b1;
`endif
        WAIT_DONE: if (!busy) begin
          rr_ptr <= nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with a simple UART busy model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_par_en = '0, req_par_typ = '0, req_ready;
  logic [N*8-1:0] req_data = '0;
  logic busy = 1'b0;
  logic [7:0] P_DATA;
  logic Data_Valid, PAR_EN, PAR_TYP, arb_busy, wdog_err;
  logic [1:0] grant_id;
  int checks = 0, errors = 0, viol = 0, bcnt = 0;
  bit auto_busy = 1'b1;
  logic [9:0] log_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .WDOG_CYC(16)) dut (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ), .req_ready(req_ready),
    .busy(busy), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .grant_id(grant_id), .arb_busy(arb_busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  // UART_TX stand-in: busy rises the edge after Data_Valid and stays high 5 cycles
  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (Data_Valid && auto_busy) begin
      busy <= 1'b1;
      bcnt <= 5;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy <= 1'b0;
    end
  end

  // Record every issued frame and any Data_Valid seen while busy
  always @(negedge clk) begin
    if (Data_Valid) begin
      log_q.push_back({grant_id, P_DATA});
      if (busy) viol <= viol + 1;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic run_grants(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = '0;
    for (int i = 0; i < 100; i++) begin
      if (!arb_busy && !busy) break;
      @(negedge clk);
    end
    if (arb_busy || busy) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'h44332211;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", Data_Valid); end
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy: got %b expected 0", arb_busy); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b expected 0", wdog_err); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    @(negedge clk);
    log_q.delete();
    req_data[7:0] = 8'hA5;
    req_par_en = 4'b0001;
    req_par_typ = 4'b0000;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL single_dv: got %b expected 1", Data_Valid); end
    checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL single_pdata: got %h expected a5", P_DATA); end
    checks++; if (PAR_EN !== 1'b1 || PAR_TYP !== 1'b0) begin errors++; $display("FAIL single_par: got en=%b typ=%b expected en=1 typ=0", PAR_EN, PAR_TYP); end
    checks++; if (req_ready !== 4'b0000 || arb_busy !== 1'b1) begin errors++; $display("FAIL single_issue_state: got ready=%b arb_busy=%b expected 0000/1", req_ready, arb_busy); end
    @(negedge clk);
    checks++; if (Data_Valid !== 1'b0 || P_DATA !== 8'hA5) begin errors++; $display("FAIL single_pulse: got dv=%b pdata=%h expected 0/a5", Data_Valid, P_DATA); end
    run_grants(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got ok=%b expected 1", ok); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] eg[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] ed[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    apply_reset();
    req_data = 32'h44332211;
    req_par_en = '0;
    req_valid = 4'b1111;
    run_grants(5, ok);
    checks++; if (!ok || log_q.size() != 5) begin errors++; $display("FAIL rr_count: got %0d frames expected 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== {eg[i], ed[i]}) begin errors++; $display("FAIL rr_frame%0d: got id=%0d data=%h expected id=%0d data=%h", i, log_q[i][9:8], log_q[i][7:0], eg[i], ed[i]); end
    end
  endtask

  task automatic test_contention_wrap();
    bit ok;
    logic [1:0] eg[3] = '{2'd3, 2'd0, 2'd3};
    apply_reset();
    req_valid = 4'b0100;
    run_grants(1, ok);
    checks++; if (!ok || log_q[0] !== {2'd2, 8'h33}) begin errors++; $display("FAIL wrap_setup: got %h expected 233", log_q[0]); end
    log_q.delete();
    req_valid = 4'b1001;
    run_grants(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_count: got %0d frames expected 3", log_q.size()); end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      checks++; if (log_q[i][9:8] !== eg[i]) begin errors++; $display("FAIL wrap_grant%0d: got %0d expected %0d", i, log_q[i][9:8], eg[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    req_valid = 4'b0010;
    run_grants(3, ok);
    checks++; if (!ok || log_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d frames expected 3", log_q.size()); end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== {2'd1, 8'h22}) begin errors++; $display("FAIL b2b_frame%0d: got %h expected 122", i, log_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    apply_reset();
    req_valid = 4'b0010;
    run_grants(1, ok);
    req_valid = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_busy: got busy=%b expected 1", busy); end
    rst = 1'b1;
    req_valid = 4'b0110;
    @(negedge clk);
    checks++; if (arb_busy !== 1'b0 || Data_Valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got arb_busy=%b dv=%b expected 0/0", arb_busy, Data_Valid); end
    checks++; if (P_DATA !== 8'h00 || grant_id !== 2'd0) begin errors++; $display("FAIL midrst_outs: got pdata=%h id=%0d expected 00/0", P_DATA, grant_id); end
    rst = 1'b0;
    log_q.delete();
    run_grants(1, ok);
    checks++; if (!ok || log_q[0] !== {2'd1, 8'h22}) begin errors++; $display("FAIL midrst_rearb: got %h expected 122", log_q[0]); end
  endtask

`ifdef UART_ARB_WDOG_EN
  task automatic test_watchdog();
    int n;
    apply_reset();
    auto_busy = 1'b0;
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wdog_accept: got %b expected 0001", req_ready); end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (wdog_err) begin
        n = i;
        break;
      end
    end
    checks++; if (n != 18) begin errors++; $display("FAIL wdog_time: got %0d expected 18", n); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wdog_next: got %b expected 0010", req_ready); end
    @(negedge clk);
    checks++; if (wdog_err !== 1'b0 || Data_Valid !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL wdog_after: got err=%b dv=%b id=%0d expected 0/1/1", wdog_err, Data_Valid, grant_id); end
    auto_busy = 1'b1;
    apply_reset();
  endtask
`endif

  task automatic test_no_dv_while_busy();
    checks++; if (viol != 0) begin errors++; $display("FAIL dv_while_busy: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_contention_wrap();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_ARB_WDOG_EN
    test_watchdog();
`endif
    test_no_dv_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
